// File: rtl/uart_rx.sv
// UART receive path: oversampled start-edge detection, mid-bit sampling,
// optional parity and stop-bit checking, valid/ready word delivery.
module uart_rx #(
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0
) (
  input  logic                 SysClk,
  input  logic                 Rst_n,
  input  logic                 RxD,
  input  logic                 RxReady,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 FrameErr,
  output logic                 ParityErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int unsigned BIT_CYCLES = SYSCLK_RATE / BAUD_RATE;
  localparam int unsigned HALF       = BIT_CYCLES / 2;
  localparam int unsigned CW         = $clog2(BIT_CYCLES);
  localparam int unsigned BW         = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          USE_PAR  = (PARITY_EN != 0);
  localparam logic          ODD_PAR  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic                 meta_q, sync_q, hist_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;

  logic fall, cnt_last, mid_hit, sample, complete, accept;

  // Line synchronizer plus one history flop for edge detection; idle-high reset.
  always_ff @(posedge SysClk) begin
    if (!Rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= RxD;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign fall     = hist_q & ~sync_q;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign mid_hit  = (cnt_q == CNT_MID);

  always_ff @(posedge SysClk) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START:  if (mid_hit) state_d = sync_q ? S_IDLE : S_DATA;
      S_DATA:   if (cnt_last && (bitcnt_q == BIT_LAST)) state_d = USE_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (cnt_last) state_d = S_STOP;
      S_STOP:   if (cnt_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sample    = 1'b0;
    complete  = 1'b0;
    accept    = valid_q & RxReady;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    ovr_d     = ovr_q;
    Busy      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE:   par_err_d = 1'b0;
      S_START:  sample = mid_hit;
      S_DATA: begin
        sample = cnt_last;
        if (cnt_last) begin
          shift_d  = {sync_q, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + BW'(1);
        end
      end
      S_PARITY: begin
        sample = cnt_last;
        if (cnt_last) par_err_d = ((^shift_q) ^ sync_q) != ODD_PAR;
      end
      S_STOP: begin
        sample   = cnt_last;
        complete = cnt_last;
      end
      default: ;
    endcase

    if (state_q == S_IDLE || state_d != state_q || sample) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (state_d == S_DATA && state_q != S_DATA) begin
      bitcnt_d = '0;
    end

    // A completion wins over acceptance; it only counts as overrun if the held word was not taken.
    if (complete) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~sync_q;
      perr_d  = par_err_q & USE_PAR;
      ovr_d   = valid_q & ~RxReady;
    end else if (accept) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge SysClk) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign RxData    = data_q;
  assign RxValid   = valid_q;
  assign FrameErr  = ferr_q;
  assign ParityErr = perr_q;
  assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance at 16 clocks per bit.
module tb_uart_rx;
  localparam int BC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rxd0, rxd1, rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       val0, fe0, pe0, ov0, busy0;
  logic       val1, fe1, pe1, ov1, busy1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int vrise0 = -1, brise0 = -1, bfall0 = -1, vrise1 = -1;
  logic pv0 = 1'b0, pb0 = 1'b0, pv1 = 1'b0;
  int k, kb;

  uart_rx #(.SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .SysClk(clk), .Rst_n(rst_n), .RxD(rxd0), .RxReady(rdy0), .RxData(data0), .RxValid(val0),
    .FrameErr(fe0), .ParityErr(pe0), .Overrun(ov0), .Busy(busy0));

  uart_rx #(.SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .SysClk(clk), .Rst_n(rst_n), .RxD(rxd1), .RxReady(rdy1), .RxData(data1), .RxValid(val1),
    .FrameErr(fe1), .ParityErr(pe1), .Overrun(ov1), .Busy(busy1));

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Word layout in the queues: {Overrun, ParityErr, FrameErr, RxData}.
  task automatic mon_pop(input int which, input logic [10:0] got);
    logic [10:0] exp;
    if (which == 0 && q0.size() == 0 || which == 1 && q1.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL mon%0d_unexpected got 0x%0h expected no word", which, got);
    end else begin
      exp = (which == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("mon%0d_word", which), int'(got), int'(exp));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [11:0] bits, input int n, output int k0);
    k0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (which == 0) rxd0 = bits[i];
      else            rxd1 = bits[i];
      idle(BC);
    end
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] d, input logic stop);
    return {2'b00, stop, d, 1'b0};
  endfunction

  function automatic logic [11:0] f8p1(input logic [7:0] d, input logic par);
    return {1'b0, 1'b1, par, d, 1'b0};
  endfunction

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (val0 && !pv0) vrise0 = cyc;
        if (busy0 && !pb0) brise0 = cyc;
        if (!busy0 && pb0) bfall0 = cyc;
        if (val1 && !pv1) vrise1 = cyc;
        pv0 = val0;
        pb0 = busy0;
        pv1 = val1;
        if (val0 && rdy0) mon_pop(0, {ov0, pe0, fe0, data0});
        if (val1 && rdy1) mon_pop(1, {ov1, pe1, fe1, data1});
      end
    join_none

    rst_n = 1'b0;
    rxd0 = 1'b1; rxd1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    idle(3);
    chk("rst_valid0", val0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_flags0", {ov0, pe0, fe0}, 0);
    chk("rst_data0", data0, 0);
    chk("rst_valid1", val1, 0);
    chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    idle(5);

    // 8N1 0xA5, timing of Busy and RxValid relative to the pin edge
    q0.push_back({3'b000, 8'hA5});
    send(0, f8n1(8'hA5, 1'b1), 10, k);
    idle(20);
    chk("a5_busy_rise", brise0, k + 3);
    chk("a5_valid_rise", vrise0, k + 155);
    chk("a5_busy_fall", bfall0, k + 155);

    // 6-cycle glitch on idle line
    kb = vrise0;
    k = cyc;
    rxd0 = 1'b0;
    idle(6);
    rxd0 = 1'b1;
    idle(30);
    chk("glitch_busy_rise", brise0, k + 3);
    chk("glitch_busy_fall", bfall0, k + 11);
    chk("glitch_no_valid", vrise0, kb);

    // even parity: 0x03 with parity 1 is an error, with parity 0 is clean
    q1.push_back({3'b010, 8'h03});
    send(1, f8p1(8'h03, 1'b1), 11, k);
    idle(20);
    chk("par1_valid_rise", vrise1, k + 171);
    q1.push_back({3'b000, 8'h03});
    send(1, f8p1(8'h03, 1'b0), 11, k);
    idle(20);
    chk("par0_valid_rise", vrise1, k + 171);

    // stop bit low, line then held low for 40 bit times
    q0.push_back({3'b001, 8'h3C});
    send(0, f8n1(8'h3C, 1'b0), 10, k);
    idle(40 * BC);
    chk("ferr_valid_rise", vrise0, k + 155);
    rxd0 = 1'b1;
    idle(50);
    chk("ferr_no_retrigger", vrise0, k + 155);

    // overrun: two back-to-back words with no consumer
    rdy0 = 1'b0;
    q0.push_back({3'b100, 8'h22});
    send(0, f8n1(8'h11, 1'b1), 10, k);
    send(0, f8n1(8'h22, 1'b1), 10, kb);
    idle(20);
    chk("ovr_valid_held", val0, 1);
    chk("ovr_data", data0, 8'h22);
    chk("ovr_flag", ov0, 1);
    rdy0 = 1'b1;
    idle(1);
    rdy0 = 1'b0;
    chk("ovr_valid_clear", val0, 0);
    chk("ovr_flag_clear", ov0, 0);
    rdy0 = 1'b1;
    idle(10);

    // reset pulse during data bit 3 of 0xFF
    fork
      send(0, f8n1(8'hFF, 1'b1), 10, k);
      begin
        idle(70);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_valid", val0, 0);
        chk("midrst_data", data0, 0);
        chk("midrst_flags", {ov0, pe0, fe0}, 0);
      end
    join
    idle(20);
    chk("midrst_busy_fall", bfall0, k + 71);
    kb = vrise0;
    chk("midrst_no_word", val0, 0);
    q0.push_back({3'b000, 8'h5A});
    send(0, f8n1(8'h5A, 1'b1), 10, k);
    idle(30);
    chk("5a_valid_rise", vrise0, k + 155);

    idle(20);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
